m_seq_gen: RTL and testbench
============================

Name: m_seq_gen

Overview:
- Parametrised maximal-length sequence (m-sequence) generator built on a Galois LFSR.
- Adds these capabilities:
  - configurable register width and feedback polynomial
  - OUT_W bits per output beat
  - one-shot or continuous mode
  - valid/ready backpressure on the output
  - zero-seed protection
- Feeds PRBS test streams to link/BER blocks and scramblers in the seminar designs.

Parameters:
- WIDTH, 10: LFSR width in bits; period L = 2^WIDTH-1 bits (WIDTH 3..16).
- POLY, 10'h009: Galois feedback mask, WIDTH bits; XORed into the shifted register when the old MSB is 1.
- OUT_W, 1: sequence bits per output beat (1..WIDTH).

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- start, input, 1: one-cycle request to begin a run; sampled in IDLE only.
- mode, input, 1: 0 = one-shot (exactly L bits), 1 = continuous; latched on accepted start.
- stop, input, 1: end a continuous run; sampled in RUN only.
- seed, input, WIDTH: initial LFSR value; sampled on accepted start.
- out_ready, input, 1: downstream can accept a beat.
- out_valid, output, 1: out_data holds a valid beat.
- out_data, output, OUT_W: beat; bit OUT_W-1 is the earliest sequence bit.
- out_last, output, 1: final beat of a one-shot run; qualified by out_valid.
- busy, output, 1: state is RUN.
- done, output, 1: one-cycle pulse when a run finishes.
- seed_err, output, 1: one-cycle pulse when a zero seed is replaced.

Behaviour:
- Reset (rst=0, async): state IDLE; lfsr=0, bit count=0; all outputs 0.
- Single step: lfsr' = {lfsr[WIDTH-2:0],1'b0} ^ (POLY & {WIDTH{lfsr[WIDTH-1]}}). The emitted bit is lfsr'[WIDTH-1].
- Beat production: OUT_W steps chained combinationally within one cycle. Per-beat bits appear MSB-first in emission order.
- States: IDLE, RUN.
- IDLE -> RUN on start=1:
  - Seed handling: if seed==0, an effective seed of 1 is used and seed_err pulses the next cycle.
  - At that same edge: mode latched; first beat computed from the effective seed into out_data; out_valid=1; lfsr holds the post-beat value; bit count = bits emitted.
  - Latency: out_valid rises exactly 1 cycle after start.
- Handshake:
  - A beat transfers on out_valid & out_ready.
  - While out_valid & ~out_ready, out_data, out_last and the LFSR hold unchanged.
  - On a transfer, the next beat loads at the same edge with no bubble, so full throughput is one beat per cycle.
- One-shot mode:
  - Bit count runs 0..L.
  - The beat reaching L bits sets out_last. If L mod OUT_W != 0, that beat's unused low bits are 0 and the LFSR is not stepped for the padding.
  - Final transfer: out_valid=0 and state IDLE at the next edge; done pulses in the cycle after the final transfer.
  - At that point the LFSR equals the effective seed.
- Continuous mode:
  - The sequence wraps seamlessly across period boundaries, with no padding.
  - Bit count wraps modulo L.
  - out_last is held at 0.
- stop in RUN:
  - Latched into a pending flag.
  - The run ends at the next transfer, including one in the same cycle. The beat in flight is always delivered, never dropped or truncated.
  - After that transfer: out_valid=0, IDLE, done pulses next cycle.
  - stop in one-shot mode also ends the run early, with out_last=0.
- Ignored inputs: start in RUN; stop in IDLE.
- Simultaneous start and stop in IDLE: start accepted, stop ignored.
- Reset mid-run: immediate return to IDLE, no done pulse, the beat is lost.
- Back-to-back runs: start is honoured in the same cycle done is high, since the state is already IDLE.
- busy equals (state==RUN).

Test Plan:
1. Defaults (WIDTH=10, POLY=009, OUT_W=1), seed=10'h001, mode=0, out_ready=1 -> exactly 1023 beats, 512 ones; out_last only on beat 1023; done pulses 1 cycle later; final lfsr=10'h001.
2. WIDTH=4, POLY=4'h3, OUT_W=1, seed=4'h1, one-shot -> bits 0,0,1,0,0,1,1,0,1,0,1,1,1,1,0; done after bit 15.
3. Same polynomial and seed, OUT_W=4 -> beats 4'h2, 4'h6, 4'hB, 4'hC with out_last on the 4'hC beat (one pad bit); 4 transfers total.
4. Backpressure: out_ready pattern 1,0,0,1 repeating on case 2 -> out_data stable during stalls; bit sequence identical to case 2; done only after the 15th transfer.
5. seed=0, WIDTH=4 case -> seed_err pulse 1 cycle after start; output identical to case 2.
6. Continuous mode, case 2 configuration:
   - Run for 20 beats -> beat 16 repeats beat 1.
   - stop asserted while a stalled beat is pending -> that beat is still delivered, then done pulses.
   - Reset asserted mid-run -> all outputs 0 asynchronously, no done pulse.

Source files
------------

// File: rtl/m_seq_gen.sv
// Galois-LFSR m-sequence generator: OUT_W bits per beat, one-shot or continuous runs.
// First beat is valid 1 cycle after start; a stalled beat holds data, last flag and LFSR.
module m_seq_gen #(
    parameter int unsigned      WIDTH = 10,
    parameter logic [WIDTH-1:0] POLY  = 10'h009,
    parameter int unsigned      OUT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             stop,
    input  logic [WIDTH-1:0] seed,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             seed_err
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [WIDTH:0] LEN  = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] BEAT = (WIDTH+1)'(OUT_W);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] lfsr, lfsr_nxt;
    logic [WIDTH:0]   cnt, cnt_nxt;
    logic             mode_q, mode_nxt;
    logic             stop_pend, pend_nxt;
    logic             vld_nxt, last_nxt, done_nxt, serr_nxt;
    logic [OUT_W-1:0] dat_nxt;

    logic [WIDTH-1:0] src_lfsr, b_lfsr;
    logic [WIDTH:0]   src_cnt, b_cnt, b_rem, b_take, b_sum;
    logic             src_mode, b_last;
    logic [OUT_W-1:0] b_dat;
    logic             xfer, seed_zero;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], 1'b0} ^ (POLY & {WIDTH{v[WIDTH-1]}});
    endfunction

    assign seed_zero = (seed == '0);
    assign xfer      = out_valid & out_ready;
    assign busy      = (state == RUN);

    // In IDLE the beat engine works from the (zero-protected) seed, in RUN from the live register.
    always_comb begin
        if (state == IDLE) begin
            src_lfsr = seed_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : seed;
            src_cnt  = '0;
            src_mode = mode;
        end else begin
            src_lfsr = lfsr;
            src_cnt  = cnt;
            src_mode = mode_q;
        end
    end

    // One-shot runs emit only the bits left in the period; the rest of the beat is zero padding.
    always_comb begin
        b_rem  = LEN - src_cnt;
        b_take = (!src_mode && (b_rem < BEAT)) ? b_rem : BEAT;
        b_sum  = src_cnt + b_take;
        b_cnt  = (src_mode && (b_sum >= LEN)) ? (b_sum - LEN) : b_sum;
        b_last = !src_mode && (b_sum == LEN);
        b_lfsr = src_lfsr;
        b_dat  = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if ((WIDTH+1)'(i) < b_take) begin
                b_lfsr               = lfsr_step(b_lfsr);
                b_dat[OUT_W-1-i]     = b_lfsr[WIDTH-1];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        cnt_nxt   = cnt;
        mode_nxt  = mode_q;
        pend_nxt  = stop_pend;
        vld_nxt   = out_valid;
        dat_nxt   = out_data;
        last_nxt  = out_last;
        done_nxt  = 1'b0;
        serr_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    mode_nxt  = mode;
                    pend_nxt  = 1'b0;
                    lfsr_nxt  = b_lfsr;
                    cnt_nxt   = b_cnt;
                    vld_nxt   = 1'b1;
                    dat_nxt   = b_dat;
                    last_nxt  = b_last;
                    serr_nxt  = seed_zero;
                end
            end
            RUN: begin
                if (stop) pend_nxt = 1'b1;
                if (xfer) begin
                    if (out_last || stop_pend || stop) begin
                        state_nxt = IDLE;
                        vld_nxt   = 1'b0;
                        dat_nxt   = '0;
                        last_nxt  = 1'b0;
                        pend_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        lfsr_nxt  = b_lfsr;
                        cnt_nxt   = b_cnt;
                        dat_nxt   = b_dat;
                        last_nxt  = b_last;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lfsr      <= '0;
            cnt       <= '0;
            mode_q    <= 1'b0;
            stop_pend <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            seed_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            lfsr      <= lfsr_nxt;
            cnt       <= cnt_nxt;
            mode_q    <= mode_nxt;
            stop_pend <= pend_nxt;
            out_valid <= vld_nxt;
            out_data  <= dat_nxt;
            out_last  <= last_nxt;
            done      <= done_nxt;
            seed_err  <= serr_nxt;
        end
    end

endmodule

// File: tb/tb_m_seq_gen.sv
// Bench for m_seq_gen: three configurations driven from one directed/random sequence.
module tb_m_seq_gen;

    logic       clk = 1'b0;
    logic       rst, start, mode, stop, out_ready;
    logic [9:0] seed_v;
    int         sel;
    int         checks, errors;

    logic       st [3];
    logic       vld [3], lst [3], bsy [3], dn [3], se [3];
    logic [0:0] dat0, dat2;
    logic [3:0] dat1;

    logic       o_valid, o_last, o_busy, o_done, o_serr;
    logic [3:0] o_data;

    int  exp_dat[$];
    bit  exp_last[$];
    int  got_q[$];
    int  last_ones;
    int  c2 [15] = '{0,0,1,0,0,1,1,0,1,0,1,1,1,1,0};
    int  c3 [4]  = '{2,6,11,12};

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_st
        assign st[k] = start && (sel == k);
    end

    m_seq_gen #(.WIDTH(4), .POLY(4'h3), .OUT_W(1)) u_d0 (
        .clk(clk), .rst(rst), .start(st[0]), .mode(mode), .stop(stop), .seed(seed_v[3:0]),
        .out_ready(out_ready), .out_valid(vld[0]), .out_data(dat0), .out_last(lst[0]),
        .busy(bsy[0]), .done(dn[0]), .seed_err(se[0]));

    m_seq_gen #(.WIDTH(4), .POLY(4'h3), .OUT_W(4)) u_d1 (
        .clk(clk), .rst(rst), .start(st[1]), .mode(mode), .stop(stop), .seed(seed_v[3:0]),
        .out_ready(out_ready), .out_valid(vld[1]), .out_data(dat1), .out_last(lst[1]),
        .busy(bsy[1]), .done(dn[1]), .seed_err(se[1]));

    m_seq_gen #(.WIDTH(10), .POLY(10'h009), .OUT_W(1)) u_d2 (
        .clk(clk), .rst(rst), .start(st[2]), .mode(mode), .stop(stop), .seed(seed_v),
        .out_ready(out_ready), .out_valid(vld[2]), .out_data(dat2), .out_last(lst[2]),
        .busy(bsy[2]), .done(dn[2]), .seed_err(se[2]));

    always_comb begin
        o_valid = vld[0]; o_last = lst[0]; o_busy = bsy[0]; o_done = dn[0]; o_serr = se[0];
        o_data  = {3'b000, dat0};
        if (sel == 1) begin
            o_valid = vld[1]; o_last = lst[1]; o_busy = bsy[1]; o_done = dn[1]; o_serr = se[1];
            o_data  = dat1;
        end else if (sel == 2) begin
            o_valid = vld[2]; o_last = lst[2]; o_busy = bsy[2]; o_done = dn[2]; o_serr = se[2];
            o_data  = {3'b000, dat2};
        end
    end

    function automatic int wof(input int d);  return (d == 2) ? 10 : 4; endfunction
    function automatic int pof(input int d);  return (d == 2) ? 9 : 3;  endfunction
    function automatic int owof(input int d); return (d == 1) ? 4 : 1;  endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: the raw bit stream of the sequence, then cut into beats.
    task automatic build(input int d, input int sd, input bit md, input int nb);
        int w, p, ow, len, v, nbits, x, msb;
        bit bits[$];
        w = wof(d); p = pof(d); ow = owof(d);
        len   = (1 << w) - 1;
        v     = (sd == 0) ? 1 : sd;
        nbits = md ? nb * ow : len;
        exp_dat.delete();
        exp_last.delete();
        for (int i = 0; i < nbits; i++) begin
            msb = (v >> (w - 1)) & 1;
            v   = ((v << 1) & len) ^ ((msb != 0) ? p : 0);
            bits.push_back(((v >> (w - 1)) & 1) != 0);
        end
        for (int b = 0; b * ow < nbits; b++) begin
            x = 0;
            for (int j = 0; j < ow; j++)
                x = (x << 1) | ((b * ow + j < nbits && bits[b * ow + j]) ? 1 : 0);
            exp_dat.push_back(x);
            exp_last.push_back(!md && ((b + 1) * ow >= nbits));
        end
    endtask

    // rmode: 0 always ready, 1 ready pattern 1,0,0,1, 2 random ready.
    task automatic run(input int d, input int sd, input bit md, input int stop_at, input int rmode);
        int n, idx, cyc;
        bit rdy, stop_sent;
        build(d, sd, md, stop_at);
        n = (stop_at > 0 && stop_at < exp_dat.size()) ? stop_at : exp_dat.size();
        got_q.delete();
        last_ones = 0;
        sel    = d;
        seed_v = 10'(sd);
        mode   = md;
        start  = 1'b1;
        stop   = (stop_at < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        #1;
        chk("pre_valid", 32'(o_valid), 32'(0));
        tick;
        start = 1'b0;
        stop  = 1'b0;
        chk("lat_valid", 32'(o_valid), 32'(1));
        chk("seed_err", 32'(o_serr), 32'(sd == 0));
        idx = 0; cyc = 0; stop_sent = 0;
        while (idx < n && cyc < 4000) begin
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (stop_at > 0 && idx == n - 1 && !stop_sent) begin
                stop = 1'b1;
                stop_sent = 1'b1;
                if (rmode != 0) rdy = 1'b0;
            end else begin
                stop = 1'b0;
            end
            out_ready = rdy;
            start     = 1'($urandom_range(0, 1));
            if (cyc > 0) chk("seed_err_pulse", 32'(o_serr), 32'(0));
            chk("done_low", 32'(o_done), 32'(0));
            chk("valid", 32'(o_valid), 32'(1));
            chk("busy", 32'(o_busy), 32'(1));
            chk($sformatf("data[%0d]", idx), 32'(o_data), 32'(exp_dat[idx]));
            chk($sformatf("last[%0d]", idx), 32'(o_last), 32'(exp_last[idx]));
            if (rdy) begin
                got_q.push_back(int'(o_data));
                last_ones += $countones(o_data);
                idx++;
            end
            tick;
            cyc++;
        end
        start = 1'b0;
        stop  = 1'b0;
        out_ready = 1'b0;
        chk("timeout", 32'(cyc < 4000), 32'(1));
        chk("end_valid", 32'(o_valid), 32'(0));
        chk("end_busy", 32'(o_busy), 32'(0));
        chk("end_done", 32'(o_done), 32'(1));
    endtask

    task automatic idle_chk;
        stop = 1'b1;
        tick;
        stop = 1'b0;
        chk("idle_done", 32'(o_done), 32'(0));
        chk("idle_busy", 32'(o_busy), 32'(0));
        chk("idle_valid", 32'(o_valid), 32'(0));
    endtask

    task automatic cmp_c2(input string tag);
        chk({tag, "_n"}, 32'(got_q.size()), 32'(15));
        for (int i = 0; i < 15; i++)
            chk($sformatf("%s_bit%0d", tag, i), (i < got_q.size()) ? 32'(got_q[i]) : 'x, 32'(c2[i]));
    endtask

    initial begin
        int d, w, sd, sa;
        bit md;
        checks = 0; errors = 0;
        rst = 1'b0; start = 1'b0; mode = 1'b0; stop = 1'b0; out_ready = 1'b0;
        seed_v = '0; sel = 0;
        tick; tick;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst_valid", 32'(o_valid), 32'(0));
            chk("rst_data", 32'(o_data), 32'(0));
            chk("rst_last", 32'(o_last), 32'(0));
            chk("rst_busy", 32'(o_busy), 32'(0));
            chk("rst_done", 32'(o_done), 32'(0));
            chk("rst_serr", 32'(o_serr), 32'(0));
        end
        rst = 1'b1;
        tick;

        run(2, 1, 1'b0, -1, 0);
        chk("t1_beats", 32'(got_q.size()), 32'(1023));
        chk("t1_ones", 32'(last_ones), 32'(512));
        chk("t1_lfsr", 32'(u_d2.lfsr), 32'(10'h001));
        idle_chk;

        run(0, 1, 1'b0, -1, 0);
        cmp_c2("t2");
        chk("t2_lfsr", 32'(u_d0.lfsr), 32'(1));
        idle_chk;

        run(1, 1, 1'b0, -1, 0);
        chk("t3_n", 32'(got_q.size()), 32'(4));
        for (int i = 0; i < 4; i++)
            chk($sformatf("t3_beat%0d", i), (i < got_q.size()) ? 32'(got_q[i]) : 'x, 32'(c3[i]));
        idle_chk;

        run(0, 1, 1'b0, -1, 1);
        cmp_c2("t4");
        idle_chk;

        run(0, 0, 1'b0, -1, 0);
        cmp_c2("t5");
        idle_chk;

        run(0, 1, 1'b1, 20, 1);
        chk("t6_n", 32'(got_q.size()), 32'(20));
        if (got_q.size() > 15) chk("t6_wrap", 32'(got_q[15]), 32'(got_q[0]));
        idle_chk;

        run(1, 7, 1'b0, -1, 2);
        run(1, 9, 1'b1, 6, 0);
        idle_chk;

        sel = 0; seed_v = 10'd5; mode = 1'b1; out_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        chk("mr_valid_pre", 32'(o_valid), 32'(1));
        #2 rst = 1'b0;
        #1;
        chk("mr_valid", 32'(o_valid), 32'(0));
        chk("mr_data", 32'(o_data), 32'(0));
        chk("mr_busy", 32'(o_busy), 32'(0));
        chk("mr_done", 32'(o_done), 32'(0));
        tick;
        rst = 1'b1;
        tick;
        chk("mr_done_after", 32'(o_done), 32'(0));
        chk("mr_busy_after", 32'(o_busy), 32'(0));

        for (int k = 0; k < 8; k++) begin
            d  = $urandom_range(0, 2);
            w  = wof(d);
            sd = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, (1 << w) - 1);
            md = 1'($urandom_range(0, 1));
            if (md) sa = $urandom_range(1, 40);
            else    sa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : -1;
            run(d, sd, md, sa, 2);
            idle_chk;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
